// File: rtl/move_executor_if.sv
// Request/response bundle between the exploit logic and the move executor.
// The exploit side is the master (drives requests), the executor is the slave.
interface move_executor_if;
  logic [5:0] start_state;
  logic [5:0] next_state;
  logic       timer_start;
  logic       target_reached;
  logic [5:0] maze_state;
  logic       move_complete;
  logic       move_error;
  logic       moving;
  logic [1:0] dir;
  logic [7:0] steps;
  logic       halted;

  modport master (
    output start_state, next_state, timer_start, target_reached,
    input  maze_state, move_complete, move_error, moving, dir, steps, halted
  );

  modport slave (
    input  start_state, next_state, timer_start, target_reached,
    output maze_state, move_complete, move_error, moving, dir, steps, halted
  );
endinterface

// File: rtl/move_executor.sv
// Physical-move side of the maze solver: validates a single-step request on
// the 6x6 grid, paces the move with a cycle timer and reports completion.
//
// state | meaning
// IDLE  | waiting for a move request or the goal flag
// CHECK | one cycle: classify latched target as legal / null / rejected
// MOVE  | timer running, moving=1
// DONE  | move_complete visible with the new maze_state
// HALT  | goal reached; absorbing until rst
module move_executor #(
  parameter int unsigned MOVE_CYCLES = 50000000
) (
  input logic           clk,
  input logic           rst,
  move_executor_if.slave mif
);

  localparam int CW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MOVE,
    S_DONE,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    tgt_q, tgt_d;
  logic [5:0]    maze_state_q, maze_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [7:0]    steps_q, steps_d;
  logic          moving_q, moving_d;
  logic          move_complete_q, move_complete_d;
  logic          move_error_q, move_error_d;
  logic          halted_q, halted_d;

  logic [5:0]    cur_m1, cur_row, cur_col;
  logic          cur_valid, tgt_valid;
  logic          adj_ok;
  logic [1:0]    adj_dir;

  // Neighbour classification of tgt relative to the current cell; row wrap
  // is excluded by the row/col guards.
  always_comb begin
    cur_m1    = maze_state_q - 6'd1;
    cur_row   = cur_m1 / 6'd6;
    cur_col   = cur_m1 % 6'd6;
    cur_valid = (maze_state_q >= 6'd1) && (maze_state_q <= 6'd36);
    tgt_valid = (tgt_q >= 6'd1) && (tgt_q <= 6'd36);
    adj_ok    = 1'b0;
    adj_dir   = 2'd0;
    if (cur_valid && tgt_valid) begin
      if ((cur_row > 6'd0) && (tgt_q == maze_state_q - 6'd6)) begin
        adj_ok  = 1'b1;
        adj_dir = 2'd0;
      end else if ((cur_col < 6'd5) && (tgt_q == maze_state_q + 6'd1)) begin
        adj_ok  = 1'b1;
        adj_dir = 2'd1;
      end else if ((cur_row < 6'd5) && (tgt_q == maze_state_q + 6'd6)) begin
        adj_ok  = 1'b1;
        adj_dir = 2'd2;
      end else if ((cur_col > 6'd0) && (tgt_q == maze_state_q - 6'd1)) begin
        adj_ok  = 1'b1;
        adj_dir = 2'd3;
      end
    end
  end

  // Next-state and registered-output computation for the sequencing FSM.
  always_comb begin
    state_d         = state_q;
    tgt_d           = tgt_q;
    maze_state_d    = maze_state_q;
    cnt_d           = cnt_q;
    dir_d           = dir_q;
    steps_d         = steps_q;
    moving_d        = moving_q;
    halted_d        = halted_q;
    move_complete_d = 1'b0;
    move_error_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mif.target_reached) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (mif.timer_start) begin
          tgt_d   = mif.next_state;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (adj_ok) begin
          dir_d    = adj_dir;
          moving_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_MOVE;
        end else if (tgt_q == maze_state_q) begin
          move_complete_d = 1'b1;
          state_d         = S_IDLE;
        end else begin
          move_complete_d = 1'b1;
          move_error_d    = 1'b1;
          state_d         = S_IDLE;
        end
      end
      S_MOVE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          maze_state_d    = tgt_q;
          moving_d        = 1'b0;
          steps_d         = (steps_q == 8'hFF) ? 8'hFF : steps_q + 8'd1;
          move_complete_d = 1'b1;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        if (mif.target_reached) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any move in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      tgt_q           <= 6'd0;
      maze_state_q    <= mif.start_state;
      cnt_q           <= '0;
      dir_q           <= 2'd0;
      steps_q         <= 8'd0;
      moving_q        <= 1'b0;
      move_complete_q <= 1'b0;
      move_error_q    <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      tgt_q           <= tgt_d;
      maze_state_q    <= maze_state_d;
      cnt_q           <= cnt_d;
      dir_q           <= dir_d;
      steps_q         <= steps_d;
      moving_q        <= moving_d;
      move_complete_q <= move_complete_d;
      move_error_q    <= move_error_d;
      halted_q        <= halted_d;
    end
  end

  assign mif.maze_state    = maze_state_q;
  assign mif.move_complete = move_complete_q;
  assign mif.move_error    = move_error_q;
  assign mif.moving        = moving_q;
  assign mif.dir           = dir_q;
  assign mif.steps         = steps_q;
  assign mif.halted        = halted_q;

endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor: each request pushes its expected
// completion (cell, error flag, steps, dir, cycle, moving length); a monitor
// pops and compares on every move_complete pulse.
module tb_move_executor;

  localparam int M = 4;

  logic clk;
  logic rst;
  move_executor_if mif();

  move_executor #(.MOVE_CYCLES(M)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] st;
    logic       err;
    logic [7:0] stp;
    logic [1:0] dir;
    int         cyc;
    int         mlen;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mov_cnt = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge, away from drives.
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #2;
    if (rst) begin
      mov_cnt = 0;
    end else begin
      if (mif.moving) mov_cnt++;
      if (mif.move_error && !mif.move_complete) begin
        chk("error_without_complete", 1, 0);
      end
      if (mif.move_complete) begin
        if (sb.size() == 0) begin
          chk("unexpected_complete", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("maze_state", int'(mif.maze_state), int'(e.st));
          chk("move_error", int'(mif.move_error), int'(e.err));
          chk("steps", int'(mif.steps), int'(e.stp));
          chk("dir", int'(mif.dir), int'(e.dir));
          chk("complete_cycle", cyc, e.cyc);
          chk("moving_cycles", mov_cnt, e.mlen);
        end
        mov_cnt = 0;
      end
    end
  end

  // Issue one request at the next falling edge; optionally record expectation.
  task automatic req(input logic [5:0] ns, input bit push, input logic [5:0] est,
                     input bit eerr, input logic [7:0] estp, input logic [1:0] edir,
                     input bit legal);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.st   = est;
      e.err  = eerr;
      e.stp  = estp;
      e.dir  = edir;
      e.cyc  = cyc + 1 + (legal ? M + 1 : 1);
      e.mlen = legal ? M : 0;
      sb.push_back(e);
    end
    mif.next_state  = ns;
    mif.timer_start = 1'b1;
    @(negedge clk);
    mif.timer_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input logic [5:0] s);
    @(negedge clk);
    rst                = 1'b1;
    mif.start_state    = s;
    mif.timer_start    = 1'b0;
    mif.target_reached = 1'b0;
    @(negedge clk);
    chk("rst_maze_state", int'(mif.maze_state), int'(s));
    chk("rst_steps", int'(mif.steps), 0);
    chk("rst_flags", int'({mif.moving, mif.move_complete, mif.move_error, mif.halted}), 0);
    chk("rst_dir", int'(mif.dir), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_maze_state", int'(mif.maze_state), int'(s));
    chk("post_rst_flags", int'({mif.moving, mif.move_complete, mif.move_error, mif.halted}), 0);
  endtask

  initial begin
    int n;
    int es;
    logic [5:0] ns;
    rst                = 1'b1;
    mif.start_state    = 6'd1;
    mif.next_state     = 6'd0;
    mif.timer_start    = 1'b0;
    mif.target_reached = 1'b0;

    do_reset(6'd1);

    // 1 -> 2 right, then walk to 6
    req(6'd2, 1'b1, 6'd2, 1'b0, 8'd1, 2'd1, 1'b1);
    wait_done();
    for (int c = 3; c <= 6; c++) begin
      req(6'(c), 1'b1, 6'(c), 1'b0, 8'(c - 1), 2'd1, 1'b1);
      wait_done();
    end
    // row wrap 6 -> 7 rejected
    req(6'd7, 1'b1, 6'd6, 1'b1, 8'd5, 2'd1, 1'b0);
    wait_done();
    // walk left back to 2
    for (int c = 5; c >= 2; c--) begin
      req(6'(c), 1'b1, 6'(c), 1'b0, 8'(5 + 6 - c), 2'd3, 1'b1);
      wait_done();
    end
    // non-adjacent, then invalid 0 and 37 back to back (second in cycle 2)
    req(6'd12, 1'b1, 6'd2, 1'b1, 8'd9, 2'd3, 1'b0);
    wait_done();
    req(6'd0, 1'b1, 6'd2, 1'b1, 8'd9, 2'd3, 1'b0);
    req(6'd37, 1'b1, 6'd2, 1'b1, 8'd9, 2'd3, 1'b0);
    wait_done();
    // 2 -> 8 down, then null move at 8
    req(6'd8, 1'b1, 6'd8, 1'b0, 8'd10, 2'd2, 1'b1);
    wait_done();
    req(6'd8, 1'b1, 6'd8, 1'b0, 8'd10, 2'd2, 1'b0);
    wait_done();

    // goal flag raised mid-move 8 -> 14: move completes, then HALT
    req(6'd14, 1'b1, 6'd14, 1'b0, 8'd11, 2'd2, 1'b1);
    idle_cycles(2);
    mif.target_reached = 1'b1;
    n = 0;
    while (!mif.move_complete && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("halt_seen_complete", int'(mif.move_complete), 1);
    chk("halted_at_complete", int'(mif.halted), 0);
    @(negedge clk);
    chk("halted_after_complete", int'(mif.halted), 1);
    wait_done();
    req(6'd15, 1'b0, 6'd0, 1'b0, 8'd0, 2'd0, 1'b0);
    idle_cycles(10);
    chk("halt_maze_state", int'(mif.maze_state), 14);
    chk("halt_still_halted", int'(mif.halted), 1);
    chk("halt_not_moving", int'(mif.moving), 0);

    do_reset(6'd1);

    // reset in cycle 3 of a move, with an ignored request during MOVE
    req(6'd2, 1'b0, 6'd0, 1'b0, 8'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("abort_moving", int'(mif.moving), 1);
    mif.next_state  = 6'd7;
    mif.timer_start = 1'b1;
    @(negedge clk);
    mif.timer_start = 1'b0;
    rst             = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_maze_state", int'(mif.maze_state), 1);
    chk("abort_moving_cleared", int'(mif.moving), 0);
    idle_cycles(10);
    chk("abort_steps", int'(mif.steps), 0);
    chk("abort_maze_state_later", int'(mif.maze_state), 1);

    // request pulsed during MOVE is dropped
    req(6'd2, 1'b1, 6'd2, 1'b0, 8'd1, 2'd1, 1'b1);
    @(negedge clk);
    mif.next_state  = 6'd3;
    mif.timer_start = 1'b1;
    @(negedge clk);
    mif.timer_start = 1'b0;
    wait_done();
    idle_cycles(8);
    chk("ignored_req_maze_state", int'(mif.maze_state), 2);
    chk("ignored_req_steps", int'(mif.steps), 1);

    // 256 alternating legal moves: steps saturates at 255
    es = 1;
    for (int i = 0; i < 256; i++) begin
      ns = (i % 2 == 0) ? 6'd1 : 6'd2;
      es = (es == 255) ? 255 : es + 1;
      req(ns, 1'b1, ns, 1'b0, 8'(es), (ns == 6'd1) ? 2'd3 : 2'd1, 1'b1);
      wait_done();
    end
    chk("steps_saturated", int'(mif.steps), 255);

    idle_cycles(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_executor.md
# move_executor

Physical-move side of the maze-solver handshake. Accepts each `next_state` / `timer_start` request from the Q-learning exploit logic and checks that the requested cell is a legal single-step neighbour. It then paces the move with a cycle timer and returns the updated `maze_state` with a one-cycle `move_complete` pulse. It also supplies the direction code for the motor driver and counts completed steps.

## Interface

Parameters:
- `MOVE_CYCLES`, default 50000000: duration of one cell move in clock cycles (1 s at 50 MHz). Must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_state`  in  6  initial cell, sampled while `rst`=1.
- `next_state`  in  6  requested destination cell, sampled when `timer_start`=1 in IDLE.
- `timer_start`  in  1  move request strobe.
- `target_reached`  in  1  goal flag from the exploit logic.
- `maze_state`  out  6  current cell, registered.
- `move_complete`  out  1  one-cycle pulse when a request is finished (moved, null or rejected).
- `move_error`  out  1  one-cycle pulse, coincident with `move_complete`, when a request is rejected.
- `moving`  out  1  high while the move timer runs.
- `dir`  out  2  direction of the current or last move: 0 up, 1 right, 2 down, 3 left. Same encoding as Q-table action index.
- `steps`  out  8  completed legal moves, saturating at 255.
- `halted`  out  1  high in HALT.

## Operation

- Grid is 6×6. Valid cells are 1..36.
  - row = (s−1)/6, col = (s−1) mod 6.
  - Cells 0 and 37..63 are invalid.
- Adjacency from cell c to cell n, where n = c is the null-move case:
  - up: n = c−6 and row(c) > 0.
  - down: n = c+6 and row(c) < 5.
  - right: n = c+1 and col(c) < 5.
  - left: n = c−1 and col(c) > 0.
  - Row wrap does not count as adjacent, so 6→7 and 7→6 are illegal.
- FSM states: IDLE, CHECK, MOVE, DONE, HALT.
- IDLE:
  - If `target_reached`=1, go to HALT. This has priority over `timer_start`.
  - Else if `timer_start`=1, latch `next_state` into `tgt` and go to CHECK.
- CHECK (always one cycle). Outcome depends on `tgt`:
  - Adjacent: load `dir`, set `moving`=1, clear the counter, go to MOVE.
  - `tgt` = `maze_state` (null move): register `move_complete`=1 for the next cycle, go to IDLE. `steps` is unchanged.
  - Otherwise (invalid or non-adjacent): register `move_complete`=1 and `move_error`=1 for the next cycle, go to IDLE. `maze_state` and `dir` are unchanged.
- MOVE:
  - Counter increments every cycle.
  - When counter = `MOVE_CYCLES`−1: set `maze_state` ← `tgt`, `moving` ← 0, `steps` ← min(`steps`+1, 255), go to DONE.
- DONE: `move_complete`=1 for this cycle.
  - Go to HALT if `target_reached`=1.
  - Else go to IDLE.
- HALT: absorbing. All requests are ignored and `maze_state` is held. Only `rst` exits.
- `timer_start` outside IDLE is ignored. It is not queued.
- `target_reached` rising during CHECK or MOVE does not abort the move. It is acted on in DONE or IDLE.

## Timing

- Reset values:
  - `maze_state` = `start_state`.
  - `move_complete`, `move_error`, `moving`, `halted` = 0.
  - `dir` = 0, `steps` = 0.
  - FSM in IDLE, counter = 0.
- `rst` takes effect at the next edge, including mid-move: the move is discarded and `maze_state` reloads `start_state`.
- Legal move, with `timer_start` sampled at edge 0:
  - CHECK in cycle 1.
  - `moving`=1 in cycles 2..`MOVE_CYCLES`+1.
  - `maze_state` updated and `move_complete`=1 in cycle `MOVE_CYCLES`+2.
  - `move_complete` and the new `maze_state` are visible in the same cycle.
- Rejected or null move: `move_complete` (and `move_error` if rejected) high in cycle 2.
  - The FSM is already in IDLE in that cycle, so a new `timer_start` in cycle 2 is accepted.
- Pulses are exactly one cycle. `halted` asserts the cycle after HALT is entered.

## Test plan

- Reset with `start_state`=1: `maze_state`=1; `steps`=0; `moving`, `move_complete`, `move_error` and `halted` all 0 during and after reset.
- `MOVE_CYCLES`=4, `timer_start` with `next_state`=2 from cell 1: `dir`=1; `moving` high cycles 2..5; `move_complete` and `maze_state`=2 in cycle 6; `steps`=1.
- From cell 6, `next_state`=7; then `next_state`=12 from 2; then `next_state`=0; then 37: each gives `move_error` + `move_complete` in cycle 2, `maze_state` unchanged, `steps` unchanged.
- Null move from 8, `next_state`=8: `move_complete` in cycle 2; no `move_error`; `moving` never high.
- `target_reached`=1 asserted mid-move 8→14: the move finishes (`maze_state`=14, `dir`=2); `halted`=1 one cycle after `move_complete`; a later `timer_start` produces no pulses; `rst` restores `maze_state`=`start_state`.
- `rst` at cycle 3 of a move, and `timer_start` pulses during MOVE: move aborted with no `move_complete`; extra requests ignored. Also run 256 legal moves and check `steps` saturates at 255.
